fetch_queue: RTL and testbench

- Instruction prefetch buffer between the instruction cache and the IF/ID pipeline register.
- Issues word-aligned fetch requests to the icache over a req/ack handshake and buffers the returned words in a small FIFO.
- Re-aligns 16-bit/32-bit (RVC) instructions and presents one instruction per cycle, with its PC and a 16-bit flag, to the IF/ID register.
- Handles branch/exception redirect by flushing the buffer and discarding any in-flight response.

---
 rtl/fetch_queue_pkg.sv | 11 +
 rtl/fq_aligner.sv | 38 +++
 rtl/fetch_queue.sv | 130 +++++++++++++
 tb/tb_fetch_queue.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared constants and FSM encoding for the instruction fetch queue.
package fetch_queue_pkg;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [1:0]  RVC_OPC_MASK = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DROP = 2'd2
  } fqState_e;
endpackage

// File: rtl/fq_aligner.sv
// Combinational instruction extraction from the head/next queue words.
// Compressed (16-bit) handling only when FETCH_QUEUE_RVC_EN is defined.
module fq_aligner
  import fetch_queue_pkg::*;
(
  input  logic [31:0] head,
  input  logic [31:0] next,
  input  logic        hw,
  input  logic        headVld,
  input  logic        nextVld,
  output logic [31:0] instr,
  output logic        is16,
  output logic        valid
);
`ifdef FETCH_QUEUE_RVC_EN
  logic [15:0] half;

  always_comb begin
    half  = hw ? head[31:16] : head[15:0];
    is16  = (half[1:0] & RVC_OPC_MASK) != RVC_OPC_MASK;
    instr = head;
    valid = headVld;
    if (is16) begin
      instr = {16'h0000, half};
    end else if (hw) begin
      // 32-bit instruction straddles the word boundary
      instr = {next[15:0], head[31:16]};
      valid = headVld & nextVld;
    end
  end
`else
  logic unusedInputs;
  assign unusedInputs = ^{next, hw, nextVld};
  assign instr = head;
  assign is16  = 1'b0;
  assign valid = headVld;
`endif
endmodule

// File: rtl/fetch_queue.sv
// Instruction prefetch buffer: icache req/ack fetch FSM, word FIFO and RVC aligner.
// Optional macro FETCH_QUEUE_RVC_EN enables compressed-instruction alignment.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int                    DEPTH      = 4,
  parameter int                    ADDR_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  Redirect,
  input  logic [ADDR_WIDTH-1:0] RedirectPC,
  input  logic                  Stall,
  output logic                  IcacheReq,
  output logic [ADDR_WIDTH-1:0] IcacheAddr,
  input  logic                  IcacheAck,
  input  logic [31:0]           IcacheData,
  output logic                  FQ_Valid,
  output logic [31:0]           FQ_Instr,
  output logic [ADDR_WIDTH-1:0] FQ_PC,
  output logic                  FQ_16BitFlag
);
  localparam int PW = $clog2(DEPTH);

  logic [31:0]           mem [DEPTH];
  logic [PW-1:0]         rdPtr, wrPtr, nextPtr;
  logic [PW:0]           count;
  logic [ADDR_WIDTH-1:0] fetchPC, headAddr, redirWord;
  fqState_e              state, stateNxt;
  logic                  reqInt, push, pop, consume, outstanding;
  logic                  hw, alValid, alIs16;
  logic [31:0]           alInstr;
  logic                  unusedPcBits;

  assign unusedPcBits = ^RedirectPC[1:0];
  assign redirWord    = {RedirectPC[ADDR_WIDTH-1:2], 2'b00};
  assign nextPtr      = rdPtr + 1'b1;

  // Only one request is ever outstanding, so IDLE sees no in-flight word.
  assign reqInt      = (state == WAIT) || ((state == IDLE) && (count < (PW+1)'(DEPTH)));
  assign IcacheReq   = reqInt & ~rst;
  assign IcacheAddr  = fetchPC;
  assign push        = IcacheAck & IcacheReq & ~Redirect;
  assign outstanding = IcacheReq & ~IcacheAck;
  assign consume     = alValid & ~Stall & ~Redirect;

  always_comb begin
    stateNxt = state;
    case (state)
      IDLE:    if (outstanding) stateNxt = WAIT;
      WAIT:    if (IcacheAck) stateNxt = IDLE;
      DROP:    if (IcacheAck) stateNxt = IDLE;
      default: stateNxt = IDLE;
    endcase
    if (Redirect && outstanding) stateNxt = DROP;
  end

`ifdef FETCH_QUEUE_RVC_EN
  logic hwNxt;

  always_comb begin
    pop   = consume;
    hwNxt = hw;
    if (consume && alIs16) begin
      hwNxt = ~hw;
      pop   = hw;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           hw <= 1'b0;
    else if (Redirect) hw <= RedirectPC[1];
    else               hw <= hwNxt;
  end
`else
  assign hw  = 1'b0;
  assign pop = consume;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      rdPtr    <= '0;
      wrPtr    <= '0;
      count    <= '0;
      fetchPC  <= RESET_PC;
      headAddr <= RESET_PC;
    end else begin
      state <= stateNxt;
      if (Redirect) begin
        rdPtr    <= '0;
        wrPtr    <= '0;
        count    <= '0;
        fetchPC  <= redirWord;
        headAddr <= redirWord;
      end else begin
        if (push) begin
          wrPtr   <= wrPtr + 1'b1;
          fetchPC <= fetchPC + ADDR_WIDTH'(4);
        end
        if (pop) begin
          rdPtr    <= rdPtr + 1'b1;
          headAddr <= headAddr + ADDR_WIDTH'(4);
        end
        count <= count + (PW+1)'(push) - (PW+1)'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wrPtr] <= IcacheData;
  end

  fq_aligner uAligner (
    .head    (mem[rdPtr]),
    .next    (mem[nextPtr]),
    .hw      (hw),
    .headVld (count != '0),
    .nextVld (count > (PW+1)'(1)),
    .instr   (alInstr),
    .is16    (alIs16),
    .valid   (alValid)
  );

  assign FQ_Valid     = alValid;
  assign FQ_Instr     = alValid ? alInstr : NOP_INSTR;
  assign FQ_16BitFlag = alValid & alIs16;
  assign FQ_PC        = headAddr + {{(ADDR_WIDTH-2){1'b0}}, hw, 1'b0};
endmodule

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (default build and FETCH_QUEUE_RVC_EN build).
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst, Redirect, Stall, IcacheAck;
  logic [31:0] RedirectPC, IcacheData;
  logic        IcacheReq, FQ_Valid, FQ_16BitFlag;
  logic [31:0] IcacheAddr, FQ_Instr, FQ_PC;
  int          checks = 0;
  int          errors = 0;

  logic [31:0] drainPC    [4] = '{32'h4, 32'h8, 32'hC, 32'h10};
  logic [31:0] drainInstr [4] = '{32'h00A00113, 32'h00080013, 32'h000C0013, 32'h00100013};

  fetch_queue #(.DEPTH(4), .ADDR_WIDTH(32), .RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .Redirect(Redirect), .RedirectPC(RedirectPC), .Stall(Stall),
    .IcacheReq(IcacheReq), .IcacheAddr(IcacheAddr), .IcacheAck(IcacheAck),
    .IcacheData(IcacheData), .FQ_Valid(FQ_Valid), .FQ_Instr(FQ_Instr), .FQ_PC(FQ_PC),
    .FQ_16BitFlag(FQ_16BitFlag)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1, "timeout");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; Redirect = 1'b0; RedirectPC = '0; Stall = 1'b0;
    IcacheAck = 1'b1; IcacheData = 32'hDEAD0013;  // ack during reset must be ignored
    tick(); tick();
    chk("rst_req", IcacheReq, 0);
    chk("rst_valid", FQ_Valid, 0);
    chk("rst_instr", FQ_Instr, 32'h13);
    chk("rst_pc", FQ_PC, 0);
    chk("rst_flag", FQ_16BitFlag, 0);

    rst = 1'b0; IcacheAck = 1'b0; #1;
    chk("req0", IcacheReq, 1);
    chk("addr0", IcacheAddr, 32'h0);
    chk("empty_valid", FQ_Valid, 0);

    // same-cycle acks
    IcacheAck = 1'b1; IcacheData = 32'h00500093;
    tick();
    chk("w0_valid", FQ_Valid, 1);
    chk("w0_instr", FQ_Instr, 32'h00500093);
    chk("w0_pc", FQ_PC, 32'h0);
    chk("w0_flag", FQ_16BitFlag, 0);
    chk("addr4", IcacheAddr, 32'h4);
    IcacheData = 32'h00A00113;
    tick();
    chk("w1_instr", FQ_Instr, 32'h00A00113);
    chk("w1_pc", FQ_PC, 32'h4);
    chk("addr8", IcacheAddr, 32'h8);

    // stall with acks still flowing fills the queue
    Stall = 1'b1;
    for (int i = 0; i < 10; i++) begin
      IcacheAck  = IcacheReq;
      IcacheData = {IcacheAddr[15:0], 16'h0013};
      tick();
    end
    IcacheAck = 1'b0;
    #1;
    chk("full_req", IcacheReq, 0);
    chk("full_addr", IcacheAddr, 32'h14);
    chk("full_instr", FQ_Instr, 32'h00A00113);

    Stall = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("drain_valid", FQ_Valid, 1);
      chk("drain_pc", FQ_PC, drainPC[i]);
      chk("drain_instr", FQ_Instr, drainInstr[i]);
      tick();
    end
    chk("drained_valid", FQ_Valid, 0);
    chk("wait_req", IcacheReq, 1);
    chk("wait_addr", IcacheAddr, 32'h14);

    // redirect while waiting: next ack is stale
    Redirect = 1'b1; RedirectPC = 32'h102;
    tick();
    Redirect = 1'b0;
    chk("drop_req", IcacheReq, 0);
    chk("drop_valid", FQ_Valid, 0);
    IcacheAck = 1'b1; IcacheData = 32'hBAD00013;
    tick();
    IcacheAck = 1'b0;
    chk("post_drop_req", IcacheReq, 1);
    chk("post_drop_addr", IcacheAddr, 32'h100);
    chk("stale_discarded", FQ_Valid, 0);
    IcacheAck = 1'b1; IcacheData = 32'h45050013; Stall = 1'b1;
    tick();
    IcacheAck = 1'b0;
    chk("redir_valid", FQ_Valid, 1);
`ifdef FETCH_QUEUE_RVC_EN
    chk("redir_pc", FQ_PC, 32'h102);
    chk("redir_instr", FQ_Instr, 32'h00004505);
    chk("redir_flag", FQ_16BitFlag, 1);
`else
    chk("redir_pc", FQ_PC, 32'h100);
    chk("redir_instr", FQ_Instr, 32'h45050013);
    chk("redir_flag", FQ_16BitFlag, 0);
`endif
    Stall = 1'b0;
    tick();
    chk("consumed_valid", FQ_Valid, 0);

    // redirect coincident with ack: word dropped, back to IDLE
    Redirect = 1'b1; RedirectPC = 32'h200; IcacheAck = 1'b1; IcacheData = 32'hBAD10013;
    tick();
    Redirect = 1'b0; IcacheAck = 1'b0;
    chk("coinc_req", IcacheReq, 1);
    chk("coinc_addr", IcacheAddr, 32'h200);
    chk("coinc_valid", FQ_Valid, 0);

`ifdef FETCH_QUEUE_RVC_EN
    // two compressed instructions in one word
    IcacheAck = 1'b1; IcacheData = 32'h00014505; Stall = 1'b1;
    tick();
    IcacheAck = 1'b0;
    chk("c0_instr", FQ_Instr, 32'h00004505);
    chk("c0_pc", FQ_PC, 32'h200);
    chk("c0_flag", FQ_16BitFlag, 1);
    Stall = 1'b0;
    tick();
    chk("c1_instr", FQ_Instr, 32'h00000001);
    chk("c1_pc", FQ_PC, 32'h202);
    chk("c1_flag", FQ_16BitFlag, 1);
    tick();
    chk("c_empty", FQ_Valid, 0);
    // compressed then a straddling 32-bit instruction
    IcacheAck = 1'b1; IcacheData = 32'h00934505;
    tick();
    IcacheAck = 1'b0;
    chk("s0_instr", FQ_Instr, 32'h00004505);
    chk("s0_pc", FQ_PC, 32'h204);
    tick();
    chk("s_needs_next", FQ_Valid, 0);
    IcacheAck = 1'b1; IcacheData = 32'h12340050;
    tick();
    IcacheAck = 1'b0;
    chk("s1_valid", FQ_Valid, 1);
    chk("s1_instr", FQ_Instr, 32'h00500093);
    chk("s1_pc", FQ_PC, 32'h206);
    chk("s1_flag", FQ_16BitFlag, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
